// File: rtl/datapath_pkg.sv
// Shared types and constants for the datapath controller: FSM states, instruction
// classes, opcode/op values, ALU encodings and instruction field positions.
package datapath_pkg;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_CALC, S_WR_REG, S_WR_IMM, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_MOVI, C_MOVR, C_ADD, C_CMP, C_AND, C_MVN
  } iclass_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_NOT_B = 2'b11;

  localparam int OPC_HI = 15, OPC_LO = 13;
  localparam int OP_HI  = 12, OP_LO  = 11;
  localparam int RN_HI  = 10, RN_LO  = 8;
  localparam int RD_HI  = 7,  RD_LO  = 5;
  localparam int SH_HI  = 4,  SH_LO  = 3;
  localparam int RM_HI  = 2,  RM_LO  = 0;
  localparam int IMM_HI = 7,  IMM_LO = 0;

  typedef struct packed {
    iclass_t     cls;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [1:0]  op;
    logic [15:0] sximm8;
  } dec_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Combinational instruction decoder: splits the latched instruction into class,
// register indices, shift code, op field and the sign-extended 8-bit immediate.
module instr_dec
  import datapath_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = ir[OPC_HI:OPC_LO];
  assign op  = ir[OP_HI:OP_LO];

  always_comb begin
    dec        = '0;
    dec.rn     = ir[RN_HI:RN_LO];
    dec.rd     = ir[RD_HI:RD_LO];
    dec.rm     = ir[RM_HI:RM_LO];
    dec.sh     = ir[SH_HI:SH_LO];
    dec.op     = op;
    dec.sximm8 = sext8(ir[IMM_HI:IMM_LO]);
    dec.cls    = C_ILL;
    if (opc == OPC_MOV) begin
      if (op == OP_MOV_IMM)      dec.cls = C_MOVI;
      else if (op == OP_MOV_REG) dec.cls = C_MOVR;
    end else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD:  dec.cls = C_ADD;
        OP_CMP:  dec.cls = C_CMP;
        OP_AND:  dec.cls = C_AND;
        default: dec.cls = C_MVN;
      endcase
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller for the simple datapath. Define
// DATAPATH_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions in ERR; otherwise they are NOPs.
module datapath_ctrl
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [15:0] datapath_in,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  state_t      state, state_d;
  logic [15:0] ir;
  dec_t        dec;

  instr_dec u_dec (.ir(ir), .dec(dec));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_d;
      if (state == S_WAIT && s) ir <= in;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (dec.cls)
          C_MOVI:               state_d = S_WR_IMM;
          C_MOVR, C_MVN:        state_d = S_GET_B;
          C_ADD, C_CMP, C_AND:  state_d = S_GET_A;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
          default:              state_d = S_ERR;
`else
          default:              state_d = S_WAIT;
`endif
        endcase
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_CALC;
      S_CALC:   state_d = (dec.cls == C_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_WAIT;
    endcase
  end

  // Moore outputs: every strobe and index is zero outside its own state.
  always_comb begin
    w        = (state == S_WAIT);
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = '0;
    ALUop    = '0;
    case (state)
      S_GET_A: begin
        readnum = dec.rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = dec.rm;
        loadb   = 1'b1;
      end
      S_CALC: begin
        loadc = 1'b1;
        shift = dec.sh;
        asel  = (dec.cls == C_MOVR);
        ALUop = (dec.cls == C_MOVR) ? ALU_ADD : dec.op;
        loads = (dec.cls == C_CMP);
      end
      S_WR_REG: begin
        write    = 1'b1;
        writenum = dec.rd;
      end
      S_WR_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = dec.rn;
      end
      default: ;
    endcase
  end

`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
  assign err = (state == S_ERR);
`else
  assign err = 1'b0;
`endif

  assign datapath_in = dec.sximm8;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench: datapath_ctrl driving a behavioural datapath, checked against an
// instruction-level reference (register file + Z flag + per-class latency/strobe counts).
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, s;
  logic [15:0] instr;
  logic        w, err, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] datapath_in;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;

  int n_chk = 0;
  int n_err = 0;

  datapath_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(instr), .w(w), .err(err),
    .datapath_in(datapath_in), .writenum(writenum), .readnum(readnum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'd0: return v;
      2'd1: return v << 1;
      2'd2: return v >> 1;
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  // ---------------- behavioural datapath driven by the controller ----------------
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc;
  logic        rz;

  function automatic logic [15:0] alu_out();
    logic [15:0] ain, bin;
    ain = asel ? 16'd0 : ra;
    bin = bsel ? datapath_in : shf(rb, shift);
    case (ALUop)
      2'b00: return ain + bin;
      2'b01: return ain - bin;
      2'b10: return ain & bin;
      default: return ~bin;
    endcase
  endfunction

  always @(posedge clk) begin
    if (write) rf[writenum] <= vsel ? datapath_in : rc;
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu_out();
    if (loads) rz <= (alu_out() == 16'd0);
  end

  // ---------------- instruction-level reference ----------------
  logic [15:0] ref_r [8];
  logic        ref_z;

  localparam int K_ILL = 0, K_MOVI = 1, K_MOVR = 2, K_ADD = 3, K_CMP = 4, K_AND = 5, K_MVN = 6;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    s       = $urandom_range(0, 1);
    instr   = 16'(($urandom() & 32'h1FFF) | 32'hA000);
    @(posedge clk);
    @(negedge clk);
    chk("rst_w", 32'(w), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_strobes", 32'({write, vsel, loada, loadb, loadc, loads, asel, bsel}), 0);
    chk("rst_idx", 32'({readnum, writenum}), 0);
    chk("rst_ctl", 32'({shift, ALUop}), 0);
    reset_n = 1'b1;
    s       = 1'b0;
  endtask

  task automatic wait_w();
    int k;
    for (k = 0; k < 30 && !w; k++) @(negedge clk);
    if (!w) chk("wait_w_timeout", 0, 1);
  endtask

  task automatic trap_check(input logic [15:0] ins);
    int ce, cw, cs;
    ce = 0; cw = 0; cs = 0;
    wait_w();
    s = 1'b1; instr = ins;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      ce += int'(err);
      cw += int'(w);
      cs += int'(write | loada | loadb | loadc | loads);
      s = $urandom_range(0, 1); instr = 16'($urandom());
    end
    chk("trap_err_cycles", ce, 7);
    chk("trap_w_cycles", cw, 0);
    chk("trap_strobes", cs, 0);
    do_reset();
  endtask

  task automatic exec(input logic [15:0] ins);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] bsh, sx, exp_val;
    logic [1:0]  exp_alu;
    logic        exp_asel, done;
    int          cls, exp_lat, n, ca, cb, cc, cs, cw, cerr;
    logic [19:0] exp_cnt;

    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
    sx  = {{8{ins[7]}}, ins[7:0]};
    bsh = shf(ref_r[rm], sh);
    cls = K_ILL;
    if (opc == 3'b110 && op == 2'b10) cls = K_MOVI;
    else if (opc == 3'b110 && op == 2'b00) cls = K_MOVR;
    else if (opc == 3'b101) cls = K_ADD + int'(op);

`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
    if (cls == K_ILL) begin
      trap_check(ins);
      return;
    end
`endif

    exp_val = '0; exp_alu = 2'b00; exp_asel = 1'b0; exp_lat = 2; exp_cnt = '0;
    case (cls)
      K_MOVI: begin exp_lat = 3; exp_val = sx; exp_cnt = {4'd0, 4'd0, 4'd0, 4'd0, 4'd1}; end
      K_MOVR: begin exp_lat = 5; exp_val = bsh; exp_asel = 1'b1;
                    exp_cnt = {4'd0, 4'd1, 4'd1, 4'd0, 4'd1}; end
      K_ADD:  begin exp_lat = 6; exp_val = ref_r[rn] + bsh; exp_alu = 2'b00;
                    exp_cnt = {4'd1, 4'd1, 4'd1, 4'd0, 4'd1}; end
      K_CMP:  begin exp_lat = 5; exp_alu = 2'b01;
                    exp_cnt = {4'd1, 4'd1, 4'd1, 4'd1, 4'd0}; end
      K_AND:  begin exp_lat = 6; exp_val = ref_r[rn] & bsh; exp_alu = 2'b10;
                    exp_cnt = {4'd1, 4'd1, 4'd1, 4'd0, 4'd1}; end
      K_MVN:  begin exp_lat = 5; exp_val = ~bsh; exp_alu = 2'b11;
                    exp_cnt = {4'd0, 4'd1, 4'd1, 4'd0, 4'd1}; end
      default: ;
    endcase

    wait_w();
    s = 1'b1; instr = ins;
    n = 0; ca = 0; cb = 0; cc = 0; cs = 0; cw = 0; cerr = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      ca += int'(loada); cb += int'(loadb); cc += int'(loadc);
      cs += int'(loads); cw += int'(write); cerr += int'(err);
      if (n == 1) chk("datapath_in", 32'(datapath_in), 32'(sx));
      if (write) begin
        chk("writenum", 32'(writenum), 32'((cls == K_MOVI) ? rn : rd));
        chk("wdata", 32'(vsel ? datapath_in : rc), 32'(exp_val));
      end
      if (loadc) begin
        chk("calc_aluop", 32'(ALUop), 32'(exp_alu));
        chk("calc_asel", 32'(asel), 32'(exp_asel));
        chk("calc_shift", 32'(shift), 32'(sh));
        chk("calc_bsel", 32'(bsel), 0);
      end
      if (w) begin
        done = 1'b1;
        s    = 1'b0;
      end else begin
        // start is only sampled in WAIT, so these pulses must be ignored
        s     = $urandom_range(0, 1);
        instr = 16'($urandom());
      end
    end
    if (!done) chk("exec_timeout", 0, 1);
    chk("latency", n, exp_lat);
    chk("strobe_counts", 32'({4'(ca), 4'(cb), 4'(cc), 4'(cs), 4'(cw)}), 32'(exp_cnt));
    chk("err_low", cerr, 0);

    case (cls)
      K_MOVI: ref_r[rn] = sx;
      K_MOVR, K_ADD, K_AND, K_MVN: ref_r[rd] = exp_val;
      K_CMP: begin
        ref_z = ((ref_r[rn] - bsh) == 16'd0);
        chk("cmp_z", 32'(rz), 32'(ref_z));
      end
      default: ;
    endcase
  endtask

  // Abort an ADD with reset while it sits in CALC: nothing may be written back.
  task automatic abort_add(input logic [15:0] ins);
    int k;
    wait_w();
    s = 1'b1; instr = ins;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    for (k = 0; k < 10 && !loadc; k++) @(negedge clk);
    chk("abort_reached_calc", 32'(loadc), 1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_w", 32'(w), 1);
    chk("abort_strobes", 32'({write, loadc, loads}), 0);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_write", 32'(write), 0);
  endtask

  function automatic logic [15:0] rand_legal();
    logic [15:0] r;
    r = 16'($urandom());
    case ($urandom_range(0, 5))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      default: r[15:11] = {3'b101, 2'($urandom_range(0, 3))};
    endcase
    return r;
  endfunction

  function automatic logic [15:0] rand_illegal();
    logic [15:0] r;
    r = 16'($urandom());
    while (r[15:13] == 3'b101 || (r[15:13] == 3'b110 && (r[12:11] == 2'b10 || r[12:11] == 2'b00)))
      r[15:11] = 5'($urandom());
    return r;
  endfunction

  initial begin
    reset_n = 1'b0; s = 1'b0; instr = '0;
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    ref_z = 1'b0;
    do_reset();

    // directed: MOV imm, MOV imm, ADD with LSL
    exec(16'hD007);
    exec(16'hD102);
    exec(16'hA148);
    chk("v2_r2", 32'(rf[2]), 16);
    // CMP equal operands sets Z
    exec(16'hD007);
    exec(16'hA800);
    chk("v3_z", 32'(rz), 1);
    // negative immediate
    exec(16'hD1FF);
    chk("v4_dpin", 32'(datapath_in), 32'h0000FFFF);
    chk("v4_r1", 32'(rf[1]), 32'h0000FFFF);
    // abort mid-instruction, then illegal
    abort_add(16'hA148);
    chk("abort_r2_kept", 32'(rf[2]), 16);
    exec(16'h0000);

    for (int i = 0; i < 8; i++) exec({5'b11010, 3'(i), 8'($urandom())});
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) exec(rand_illegal());
      else exec(rand_legal());
    end
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), 32'(rf[i]), 32'(ref_r[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
